hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is hardwired zero.
REQ-002 Parameter AW, default 5: register address width; it SHALL equal clog2(NREG).
REQ-003 Parameter NRD, default 2: number of decode-stage read ports (channels).
REQ-004 Parameter CW, default 3: countdown width; maximum issue latency is 2^CW-1.
REQ-005 Parameter SCW, default 16: width of the stall performance counter.
REQ-006 clk  input  1: the single clock; all state updates on its rising edge.
REQ-007 rst  input  1: asynchronous, active-high reset.
REQ-008 issue_valid  input  1: the decode-stage instruction is valid this cycle.
REQ-009 issue_we  input  1: the issuing instruction writes a register.
REQ-010 issue_ws  input  AW: destination register of the issuing instruction.
REQ-011 issue_lat  input  CW: minimum cycles until the result reaches writeback.
REQ-012 rd_en  input  NRD: per-port read enable.
REQ-013 rd_addr  input  NRD*AW: per-port source register; port k occupies bits [k*AW +: AW].
REQ-014 flush  input  1: squash the issuing instruction this cycle.
REQ-015 wb_valid  input  1: a result is written back this cycle.
REQ-016 wb_ws  input  AW: destination register of the writeback.
REQ-017 byp_sel  output  NRD: per-port select; 1 means take the writeback data, 0 means take the register file.
REQ-018 stall_req  output  1: hold fetch and decode, and insert a bubble.
REQ-019 stall_cnt  output  SCW: saturating count of stalled cycles.
REQ-020 wb_orphan  output  1: sticky error flag; set on a writeback to a non-busy register.

Function
REQ-021 Each register r>0 SHALL hold an entry {busy, cnt[CW]}; register 0 SHALL never be busy.
REQ-022 The issue is accepted when issue_valid & issue_we & issue_ws!=0 & !stall_req & !flush.
REQ-023 On acceptance, entry[issue_ws] SHALL be set to busy=1, cnt=issue_lat at the next edge.
REQ-024 Each cycle, every busy entry with cnt>0 SHALL decrement cnt by 1; cnt SHALL saturate at 0 and never wrap.
REQ-025 The wb_match condition for register r is defined as: wb_valid & wb_ws==r & busy[r] & cnt[r]==0.
REQ-026 When wb_match holds, busy SHALL clear at the next edge.
REQ-027 A wb_valid to a register that is not busy, or that is busy with cnt>0, SHALL leave the entry unchanged and SHALL set wb_orphan.
REQ-028 Read port k SHALL assert byp_sel[k] when rd_en[k] and wb_match for rd_addr[k]; otherwise byp_sel[k]=0.
REQ-029 Port k is blocked when rd_en[k], rd_addr[k]!=0, busy[rd_addr[k]], and not wb_match for that register.
REQ-030 WAW blocking applies when issue_valid & issue_we & issue_ws!=0 & busy[issue_ws] and not wb_match for issue_ws.
REQ-031 stall_req = issue_valid & !flush & (any port blocked | WAW blocked); it is combinational, with zero-cycle latency from inputs and state.
REQ-032 Simultaneous wb_match and accepted issue to the same register: the issue SHALL win, giving busy=1 and cnt=issue_lat.
REQ-033 issue_lat=0: the register is busy for exactly one cycle minimum, and the next cycle's matching writeback is bypassable.
REQ-034 flush SHALL suppress acceptance and stall_req only; existing entries continue counting down and clearing.
REQ-035 stall_cnt SHALL increment by 1 on each cycle with stall_req=1, and SHALL hold at 2^SCW-1.
REQ-036 stall_req deasserted with issue_valid=0 SHALL not change any entry except through countdown and writeback.

Reset
REQ-037 rst=1 SHALL immediately force all busy=0, all cnt=0, stall_cnt=0, and wb_orphan=0, independent of clk.
REQ-038 While rst=1 and after release, stall_req=0 and byp_sel=0 SHALL hold until a new issue is accepted.
REQ-039 Reset asserted mid-countdown SHALL discard all pending entries; a late writeback to such a register SHALL set wb_orphan.

Verification
REQ-040 Issue x5 with lat=2, then read x5 on cycles 1-2 -> stall_req=1 for 2 cycles; at cycle 3 with wb_valid, wb_ws=5 -> stall_req=0, byp_sel[0]=1.
REQ-041 Issue x7 with lat=0 and wb_ws=7 on the next cycle, while port1 reads x7 -> byp_sel[1]=1, stall_req=0, busy[7] clears.
REQ-042 x3 busy, issue to x3 again with no writeback -> stall_req=1 (WAW); the same cycle with wb_match on x3 -> accepted, busy[3]=1, cnt=new lat.
REQ-043 Read x0 while issue_ws=0 -> never stall and never busy; wb_valid with wb_ws=9 while x9 is idle -> wb_orphan=1, sticky until rst.
REQ-044 Hold a blocked read for 70000 cycles with SCW=16 -> stall_cnt saturates at 65535.
REQ-045 Assert rst asynchronously while x4 is busy with cnt=5 -> busy[4]=0 and stall_cnt=0 before the next edge; reads of x4 do not stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Register-busy scoreboard for an in-order pipeline. Tracks, per architectural
//   register, whether a result is still in flight and how many cycles remain
//   before it can reach writeback. Produces read-after-write and write-after-write
//   stalls for the decode stage and per-read-port bypass selects that pick the
//   writeback data when it lands in the same cycle as the read.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   issue_valid   : decode-stage instruction valid
//   issue_we      : issuing instruction writes a register
//   issue_ws      : destination register of the issuing instruction
//   issue_lat     : minimum cycles until that result reaches writeback
//   rd_en         : per-port read enable
//   rd_addr       : per-port source register, port k at [k*AW +: AW]
//   flush         : squash the issuing instruction this cycle
//   wb_valid      : a result is written back this cycle
//   wb_ws         : destination register of the writeback
//   byp_sel       : per-port select, 1 = writeback data, 0 = register file
//   stall_req     : hold fetch/decode and insert a bubble
//   stall_cnt     : saturating count of stalled cycles
//   wb_orphan     : sticky flag, writeback to a register that was not ready
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2,
    parameter int unsigned CW   = 3,
    parameter int unsigned SCW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [AW-1:0]     issue_ws,
    input  logic [CW-1:0]     issue_lat,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_ws,
    output logic [NRD-1:0]    byp_sel,
    output logic              stall_req,
    output logic [SCW-1:0]    stall_cnt,
    output logic              wb_orphan
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
    logic            orphan_q, orphan_d;

    logic [NREG-1:0] wb_match;
    logic            rd_blocked;
    logic            waw_blocked;
    logic            accept;
    logic [AW-1:0]   rd_a;

    // Writeback is only a legal completion once the countdown has expired.
    always_comb begin
        wb_match = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            wb_match[r] = wb_valid && (wb_ws == AW'(r)) && busy_q[r] && (cnt_q[r] == '0);
        end
    end

    // Read ports: a same-cycle matching writeback is bypassed instead of stalled.
    always_comb begin
        byp_sel    = '0;
        rd_blocked = 1'b0;
        rd_a       = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_a       = rd_addr[k*AW +: AW];
            byp_sel[k] = rd_en[k] && wb_match[rd_a];
            if (rd_en[k] && (rd_a != '0) && busy_q[rd_a] && !wb_match[rd_a]) begin
                rd_blocked = 1'b1;
            end
        end
    end

    always_comb begin
        waw_blocked = issue_valid && issue_we && (issue_ws != '0) &&
                      busy_q[issue_ws] && !wb_match[issue_ws];
        stall_req   = issue_valid && !flush && (rd_blocked || waw_blocked);
        accept      = issue_valid && issue_we && (issue_ws != '0) && !stall_req && !flush;
    end

    // Per-entry next state: countdown, then writeback clear, then issue
    // overrides both so a same-cycle reissue wins over the retiring result.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (busy_q[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
            if (wb_match[r]) begin
                busy_d[r] = 1'b0;
            end
            if (accept && (issue_ws == AW'(r))) begin
                busy_d[r] = 1'b1;
                cnt_d[r]  = issue_lat;
            end
        end
        busy_d[0] = 1'b0;
        cnt_d[0]  = '0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_req && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
        end
        orphan_d = orphan_q || (wb_valid && !wb_match[wb_ws]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
            orphan_q    <= 1'b0;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            orphan_q    <= orphan_d;
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign wb_orphan = orphan_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard with default parameters. Inputs are
//   driven just after the falling edge, outputs are sampled 1 ns later, before
//   the rising edge that commits the cycle.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;
    localparam int unsigned CW   = 3;
    localparam int unsigned SCW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_we;
    logic [AW-1:0]     issue_ws;
    logic [CW-1:0]     issue_lat;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic              flush;
    logic              wb_valid;
    logic [AW-1:0]     wb_ws;
    logic [NRD-1:0]    byp_sel;
    logic              stall_req;
    logic [SCW-1:0]    stall_cnt;
    logic              wb_orphan;

    int unsigned errors = 0;
    int unsigned checks = 0;

    hazard_scoreboard #(
        .NREG (NREG),
        .AW   (AW),
        .NRD  (NRD),
        .CW   (CW),
        .SCW  (SCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_ws    (issue_ws),
        .issue_lat   (issue_lat),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_ws       (wb_ws),
        .byp_sel     (byp_sel),
        .stall_req   (stall_req),
        .stall_cnt   (stall_cnt),
        .wb_orphan   (wb_orphan)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and apply one cycle of inputs.
    task automatic cyc(input logic iv, input logic we, input logic [AW-1:0] ws,
                       input logic [CW-1:0] lat, input logic [NRD-1:0] ren,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra0,
                       input logic fl, input logic wv, input logic [AW-1:0] wws);
        @(negedge clk);
        issue_valid = iv;
        issue_we    = we;
        issue_ws    = ws;
        issue_lat   = lat;
        rd_en       = ren;
        rd_addr     = {ra1, ra0};
        flush       = fl;
        wb_valid    = wv;
        wb_ws       = wws;
        #1;
    endtask

    task automatic pulse_reset();
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 0; issue_we = 0; issue_ws = 0; issue_lat = 0;
        rd_en = 0; rd_addr = 0; flush = 0; wb_valid = 0; wb_ws = 0;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
        checks++; if (byp_sel !== 2'b00) begin errors++; $display("FAIL reset_byp got=%b exp=00", byp_sel); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_scnt got=%0d exp=0", stall_cnt); end
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got=%0b exp=0", wb_orphan); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_raw_bypass();
        cyc(1, 1, 5, 2, 2'b00, 0, 0, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL raw_issue got=%0b exp=0", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 5, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL raw_c1_stall got=%0b exp=1", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 5, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL raw_c2_stall got=%0b exp=1", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 5, 0, 1, 5);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL raw_c3_stall got=%0b exp=0", stall_req); end
        checks++; if (byp_sel !== 2'b01) begin errors++; $display("FAIL raw_c3_byp got=%b exp=01", byp_sel); end
        cyc(1, 0, 0, 0, 2'b01, 0, 5, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL raw_after_stall got=%0b exp=0", stall_req); end
        checks++; if (byp_sel !== 2'b00) begin errors++; $display("FAIL raw_after_byp got=%b exp=00", byp_sel); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_scnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_lat0();
        cyc(1, 1, 7, 0, 2'b00, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 2'b10, 7, 0, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lat0_busy got=%0b exp=1", stall_req); end
        cyc(1, 0, 0, 0, 2'b10, 7, 0, 0, 1, 7);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lat0_wb_stall got=%0b exp=0", stall_req); end
        checks++; if (byp_sel !== 2'b10) begin errors++; $display("FAIL lat0_byp got=%b exp=10", byp_sel); end
        cyc(1, 0, 0, 0, 2'b10, 7, 0, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lat0_clear got=%0b exp=0", stall_req); end
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL lat0_orphan got=%0b exp=0", wb_orphan); end
    endtask

    task automatic test_waw();
        cyc(1, 1, 3, 1, 2'b00, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 2, 2'b00, 0, 0, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL waw_stall got=%0b exp=1", stall_req); end
        cyc(1, 1, 3, 2, 2'b00, 0, 0, 0, 1, 3);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL waw_wb_accept got=%0b exp=0", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL waw_new_c1 got=%0b exp=1", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL waw_new_c2 got=%0b exp=1", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 3, 0, 1, 3);
        checks++; if (byp_sel !== 2'b01) begin errors++; $display("FAIL waw_final_byp got=%b exp=01", byp_sel); end
        cyc(1, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL waw_clear got=%0b exp=0", stall_req); end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL waw_scnt got=%0d exp=6", stall_cnt); end
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL waw_orphan got=%0b exp=0", wb_orphan); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 1, 4, 5, 2'b00, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 2'b01, 0, 4, 0, 0, 0);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%0b exp=1", stall_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rmid_async_stall got=%0b exp=0", stall_req); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rmid_async_scnt got=%0d exp=0", stall_cnt); end
        cyc(1, 0, 0, 0, 2'b01, 0, 4, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rmid_held_stall got=%0b exp=0", stall_req); end
        rst = 1'b0;
        cyc(1, 0, 0, 0, 2'b01, 0, 4, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rmid_post_stall got=%0b exp=0", stall_req); end
        checks++; if (byp_sel !== 2'b00) begin errors++; $display("FAIL rmid_post_byp got=%b exp=00", byp_sel); end
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4);
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL rmid_orphan_pre got=%0b exp=0", wb_orphan); end
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checks++; if (wb_orphan !== 1'b1) begin errors++; $display("FAIL rmid_orphan_late got=%0b exp=1", wb_orphan); end
    endtask

    task automatic test_orphan_early();
        pulse_reset();
        #1;
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL early_reset_orphan got=%0b exp=0", wb_orphan); end
        cyc(1, 1, 6, 3, 2'b00, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 6);
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL early_orphan_pre got=%0b exp=0", wb_orphan); end
        cyc(1, 0, 0, 0, 2'b01, 0, 6, 0, 0, 0);
        checks++; if (wb_orphan !== 1'b1) begin errors++; $display("FAIL early_orphan got=%0b exp=1", wb_orphan); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL early_still_busy got=%0b exp=1", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 6, 0, 0, 0);
        cyc(1, 0, 0, 0, 2'b01, 0, 6, 0, 1, 6);
        checks++; if (byp_sel !== 2'b01) begin errors++; $display("FAIL early_final_byp got=%b exp=01", byp_sel); end
    endtask

    task automatic test_zero_orphan();
        pulse_reset();
        cyc(1, 1, 0, 3, 2'b11, 0, 0, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL zero_c0_stall got=%0b exp=0", stall_req); end
        cyc(1, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL zero_c1_stall got=%0b exp=0", stall_req); end
        checks++; if (byp_sel !== 2'b00) begin errors++; $display("FAIL zero_c1_byp got=%b exp=00", byp_sel); end
        cyc(1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 9);
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL zero_orphan_pre got=%0b exp=0", wb_orphan); end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        checks++; if (wb_orphan !== 1'b1) begin errors++; $display("FAIL zero_orphan_sticky got=%0b exp=1", wb_orphan); end
    endtask

    task automatic test_flush();
        pulse_reset();
        cyc(1, 1, 8, 1, 2'b00, 0, 0, 1, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_c0 got=%0b exp=0", stall_req); end
        cyc(1, 0, 0, 0, 2'b01, 0, 8, 0, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_squashed got=%0b exp=0", stall_req); end
        cyc(1, 1, 8, 1, 2'b00, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 2'b01, 0, 8, 1, 0, 0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_masks_stall got=%0b exp=0", stall_req); end
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 8);
        cyc(1, 0, 0, 0, 2'b01, 0, 8, 0, 0, 0);
        checks++; if (wb_orphan !== 1'b0) begin errors++; $display("FAIL flush_countdown got=%0b exp=0", wb_orphan); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_cleared got=%0b exp=0", stall_req); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_scnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_saturation();
        pulse_reset();
        cyc(1, 1, 10, 1, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) begin
            cyc(1, 0, 0, 0, 2'b01, 0, 10, 0, 0, 0);
            if (i == 1000) begin
                checks++; if (stall_cnt !== 16'd1000) begin errors++; $display("FAIL sat_mid got=%0d exp=1000", stall_cnt); end
            end
            if (i == 65534) begin
                checks++; if (stall_cnt !== 16'd65534) begin errors++; $display("FAIL sat_edge got=%0d exp=65534", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 16'd65535) begin errors++; $display("FAIL sat_hold got=%0d exp=65535", stall_cnt); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL sat_stall got=%0b exp=1", stall_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_reset got=%0d exp=0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_raw_bypass();
        test_lat0();
        test_waw();
        test_reset_mid();
        test_orphan_early();
        test_zero_orphan();
        test_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
